// File: rtl/serial_pkg.sv
// Shared types and constants for serial_uart_port.
// SERIAL_PARITY_EN adds a PARITY state to both UART FSMs (8E1 framing).
package serial_pkg;
  localparam int   DATA_BITS  = 8;
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

`ifdef SERIAL_PARITY_EN
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;

  // Even parity: the extra bit makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] b);
    return ^b;
  endfunction
`else
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
`endif
endpackage

// File: rtl/serial_byte_fifo.sv
// First-word-fall-through FIFO: data_o shows the head whenever empty_o is low, else zero.
// Push and pop may coincide at any occupancy; a same-cycle pop frees the slot a push on full needs.
module serial_byte_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic [W-1:0]           data_i,
  input  logic                   pop_i,
  output logic [W-1:0]           data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end
endmodule

// File: rtl/serial_uart_port.sv
// Bridges the core's byte-wide serial port to a UART line through RX and TX FIFOs.
// Build with SERIAL_PARITY_EN for 8E1 frames; default is 8N1.
module serial_uart_port #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic       clock,
  input  logic       reset,
  output logic [7:0] serial_in,
  output logic       serial_valid,
  output logic       serial_ready,
  input  logic [7:0] serial_out,
  input  logic       serial_rden,
  input  logic       serial_wren,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic       rx_overrun,
  output logic       rx_error
);
  import serial_pkg::*;

  localparam int              CW       = $clog2(CLKS_PER_BIT);
  localparam int              BW       = $clog2(DATA_BITS);
  localparam int              FW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]   BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0]   LAST_BIT = BW'(DATA_BITS - 1);

  logic                 rx_push, rx_full, rx_empty;
  logic [FW-1:0]        rx_count, tx_count;
  logic                 tx_pop, tx_full, tx_empty, tx_fetch;
  logic [DATA_BITS-1:0] tx_head;

  logic                 rx_meta_q, rx_sync_q, rx_frame_ok;
  rx_state_t            rx_state_q, rx_state_d;
  logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
  logic [BW-1:0]        rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_error_q, rx_error_d, rx_overrun_q, rx_overrun_d;

  tx_state_t            tx_state_q, tx_state_d;
  logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
  logic [BW-1:0]        tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_q, tx_d;
`ifdef SERIAL_PARITY_EN
  logic                 rx_perr_q, rx_perr_d, tx_par_q, tx_par_d;
`endif

  serial_byte_fifo #(.DEPTH(FIFO_DEPTH), .W(DATA_BITS)) u_rx_fifo (
    .clock(clock), .reset(reset), .push_i(rx_push), .data_i(rx_shift_q), .pop_i(serial_rden),
    .data_o(serial_in), .full_o(rx_full), .empty_o(rx_empty), .count_o(rx_count));

  serial_byte_fifo #(.DEPTH(FIFO_DEPTH), .W(DATA_BITS)) u_tx_fifo (
    .clock(clock), .reset(reset), .push_i(serial_wren), .data_i(serial_out), .pop_i(tx_pop),
    .data_o(tx_head), .full_o(tx_full), .empty_o(tx_empty), .count_o(tx_count));

  assign serial_valid = !rx_empty;
  assign serial_ready = !tx_full;
  assign uart_tx      = tx_q;
  assign rx_error     = rx_error_q;
  assign rx_overrun   = rx_overrun_q;

  assert property (@(posedge clock) disable iff (reset) (rx_count == '0) == rx_empty);
  assert property (@(posedge clock) disable iff (reset) (tx_count == '0) == tx_empty);

`ifdef SERIAL_PARITY_EN
  assign rx_frame_ok = (rx_sync_q == STOP_BIT) && !rx_perr_q;
`else
  assign rx_frame_ok = (rx_sync_q == STOP_BIT);
`endif

  always_comb begin
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q + CW'(1);
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    rx_error_d   = rx_error_q;
    rx_overrun_d = rx_overrun_q;
    rx_push      = 1'b0;
`ifdef SERIAL_PARITY_EN
    rx_perr_d    = rx_perr_q;
`endif
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_sync_q == START_BIT) rx_state_d = RX_START;
      end
      // Mid-start recheck rejects glitches shorter than half a bit.
      RX_START: if (rx_cnt_q == HALF_END) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = (rx_sync_q == START_BIT) ? RX_DATA : RX_IDLE;
      end
      RX_DATA: if (rx_cnt_q == BIT_END) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
        rx_bit_d   = rx_bit_q + BW'(1);
`ifdef SERIAL_PARITY_EN
        if (rx_bit_q == LAST_BIT) rx_state_d = RX_PARITY;
`else
        if (rx_bit_q == LAST_BIT) rx_state_d = RX_STOP;
`endif
      end
`ifdef SERIAL_PARITY_EN
      RX_PARITY: if (rx_cnt_q == BIT_END) begin
        rx_cnt_d   = '0;
        rx_perr_d  = (rx_sync_q != even_parity(rx_shift_q));
        rx_state_d = RX_STOP;
      end
`endif
      RX_STOP: if (rx_cnt_q == BIT_END) begin
        rx_state_d = RX_IDLE;
        if (!rx_frame_ok)                   rx_error_d   = 1'b1;
        else if (rx_full && !serial_rden)   rx_overrun_d = 1'b1;
        else                                rx_push      = 1'b1;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + CW'(1);
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    tx_fetch   = 1'b0;
    tx_pop     = 1'b0;
`ifdef SERIAL_PARITY_EN
    tx_par_d   = tx_par_q;
`endif
    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        tx_d     = IDLE_LEVEL;
        tx_fetch = !tx_empty;
      end
      TX_START: if (tx_cnt_q == BIT_END) begin
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
        tx_d       = tx_shift_q[0];
        tx_state_d = TX_DATA;
      end
      TX_DATA: if (tx_cnt_q == BIT_END) begin
        tx_cnt_d   = '0;
        tx_shift_d = tx_shift_q >> 1;
        tx_bit_d   = tx_bit_q + BW'(1);
        if (tx_bit_q == LAST_BIT) begin
`ifdef SERIAL_PARITY_EN
          tx_d       = tx_par_q;
          tx_state_d = TX_PARITY;
`else
          tx_d       = STOP_BIT;
          tx_state_d = TX_STOP;
`endif
        end else begin
          tx_d = tx_shift_q[1];
        end
      end
`ifdef SERIAL_PARITY_EN
      TX_PARITY: if (tx_cnt_q == BIT_END) begin
        tx_cnt_d   = '0;
        tx_d       = STOP_BIT;
        tx_state_d = TX_STOP;
      end
`endif
      // Chaining straight into the next start bit keeps back-to-back frames gapless.
      TX_STOP: if (tx_cnt_q == BIT_END) begin
        tx_state_d = TX_IDLE;
        tx_fetch   = !tx_empty;
      end
      default: tx_state_d = TX_IDLE;
    endcase
    if (tx_fetch) begin
      tx_pop     = 1'b1;
      tx_shift_d = tx_head;
      tx_cnt_d   = '0;
      tx_d       = START_BIT;
      tx_state_d = TX_START;
`ifdef SERIAL_PARITY_EN
      tx_par_d   = even_parity(tx_head);
`endif
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta_q    <= IDLE_LEVEL;
      rx_sync_q    <= IDLE_LEVEL;
      rx_state_q   <= RX_IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      rx_error_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
      tx_state_q   <= TX_IDLE;
      tx_cnt_q     <= '0;
      tx_bit_q     <= '0;
      tx_shift_q   <= '0;
      tx_q         <= IDLE_LEVEL;
`ifdef SERIAL_PARITY_EN
      rx_perr_q    <= 1'b0;
      tx_par_q     <= 1'b0;
`endif
    end else begin
      rx_meta_q    <= uart_rx;
      rx_sync_q    <= rx_meta_q;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      rx_error_q   <= rx_error_d;
      rx_overrun_q <= rx_overrun_d;
      tx_state_q   <= tx_state_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_bit_q     <= tx_bit_d;
      tx_shift_q   <= tx_shift_d;
      tx_q         <= tx_d;
`ifdef SERIAL_PARITY_EN
      rx_perr_q    <= rx_perr_d;
      tx_par_q     <= tx_par_d;
`endif
    end
  end
endmodule
